// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO: shift-add multiply, restoring divide.
// Fixed latency of WIDTH+2 cycles from start to done, including divide-by-zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] up_q, up_d, lw_q, lw_d, dvs_q, dvs_d;
    logic             qsign_q, qsign_d, rsign_q, rsign_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dz_q, dz_d;

    logic             is_signed, is_div;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot, rem;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            up_q    <= '0;
            lw_q    <= '0;
            dvs_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            up_q    <= up_d;
            lw_q    <= lw_d;
            dvs_q   <= dvs_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        up_d    = up_q;
        lw_d    = lw_q;
        dvs_d   = dvs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        // op[0]=0 selects the signed variants; op[1]=1 selects divide
        is_signed = ~op_q[0];
        is_div    = op_q[1];
        a_abs     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        b_abs     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        mul_sum   = {1'b0, up_q} + (lw_q[0] ? {1'b0, dvs_q} : '0);
        div_shift = {up_q, lw_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, dvs_q};
        prod      = qsign_q ? -{up_q, lw_q} : {up_q, lw_q};
        quot      = qsign_q ? -lw_q : lw_q;
        rem       = rsign_q ? -up_q : up_q;

        unique case (state_q)
            S_IDLE: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (start_i) begin
                    op_d    = op_i;
                    a_d     = a_i;
                    b_d     = b_i;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                up_d    = '0;
                lw_d    = is_div ? a_abs : b_abs;
                dvs_d   = is_div ? b_abs : a_abs;
                qsign_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rsign_d = is_signed & a_q[WIDTH-1];
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (is_div) begin
                    if (!div_diff[WIDTH+1]) begin
                        up_d = div_diff[WIDTH-1:0];
                        lw_d = {lw_q[WIDTH-2:0], 1'b1};
                    end else begin
                        up_d = div_shift[WIDTH-1:0];
                        lw_d = {lw_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    up_d = mul_sum[WIDTH:1];
                    lw_d = {mul_sum[0], lw_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                    dz_d = 1'b0;
                end else if (b_q == '0) begin
                    // divide-by-zero returns all-ones quotient and the raw dividend
                    hi_d = a_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                    dz_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: result values, fixed latency, ignored inputs while busy, reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
        .busy_o(busy), .done_o(done), .div_zero_o(div_zero), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // mode 0 normal, 1 inject start/hi_we while busy, 2 reset at cycle 12, 3 hi_we with start
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int mode, output int lat_o);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (mode == 3) begin hi_we = 1'b1; wdata = 32'h0000CAFE; end
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; a = $urandom; b = $urandom; op = ~o;
        chk("busy_rise", {63'd0, busy}, 64'd1);
        if (mode == 3) chk("hi_we_with_start", {32'd0, hi}, 64'h0000CAFE);
        lat_o = -1;
        for (int c = 1; c <= 60; c++) begin
            if (mode == 1 && c == 5)  begin start = 1'b1; a = 32'd3; b = 32'd3; op = OP_MULTU; end
            if (mode == 1 && c == 6)  start = 1'b0;
            if (mode == 1 && c == 10) begin hi_we = 1'b1; wdata = 32'h0000DEAD; end
            if (mode == 1 && c == 11) hi_we = 1'b0;
            if (mode == 2 && c == 12) rst = 1'b1;
            @(posedge clk); #1;
            if (mode == 2 && c == 12) begin
                rst = 1'b0;
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_hilo", {hi, lo}, 64'd0);
            end
            if (mode != 2 && c == 33) chk("busy_hold", {63'd0, busy}, 64'd1);
            if (done) begin lat_o = c; break; end
        end
        if (mode != 2) begin
            chk("busy_fall", {63'd0, busy}, 64'd0);
            @(posedge clk); #1;
            chk("done_one_cycle", {63'd0, done}, 64'd0);
        end
    endtask

    task automatic expect_res(input string tag, input logic [31:0] eh, input logic [31:0] el,
                              input logic ez);
        chk({tag, "_lat"}, lat, 34);
        chk({tag, "_hilo"}, {hi, lo}, {eh, el});
        chk({tag, "_dz"}, {63'd0, div_zero}, {63'd0, ez});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);

        run_op(OP_MULT, -32'sd3, 32'd5, 0, lat);
        expect_res("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat);
        expect_res("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op(OP_DIV, -32'sd7, 32'd2, 0, lat);
        expect_res("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op(OP_DIVU, 32'd7, 32'd2, 0, lat);
        expect_res("divu", 32'd1, 32'd3, 1'b0);
        run_op(OP_DIV, 32'd7, -32'sd2, 0, lat);
        expect_res("div_negb", 32'd1, 32'hFFFFFFFD, 1'b0);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, lat);
        expect_res("div_ovf", 32'd0, 32'h80000000, 1'b0);
        run_op(OP_DIVU, 32'd7, 32'd0, 0, lat);
        expect_res("divu_zero", 32'd7, 32'hFFFFFFFF, 1'b1);
        run_op(OP_MULT, 32'd6, -32'sd7, 0, lat);
        expect_res("mult_clr_dz", 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
        run_op(OP_DIV, -32'sd7, 32'd0, 0, lat);
        expect_res("div_zero_neg", 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

        run_op(OP_MULT, 32'd100, 32'd200, 1, lat);
        expect_res("ignore_busy", 32'd0, 32'h00004E20, 1'b0);
        repeat (5) @(posedge clk);
        #1 chk("no_queued_op", {62'd0, busy, done}, 64'd0);

        @(negedge clk); hi_we = 1'b1; wdata = 32'h00001234;
        @(posedge clk); #1 hi_we = 1'b0;
        chk("idle_mthi", {hi, lo}, {32'h00001234, 32'h00004E20});

        run_op(OP_DIV, 32'd100, 32'd7, 2, lat);
        chk("rst_no_done", lat, -1);
        run_op(OP_MULTU, 32'd6, 32'd7, 0, lat);
        expect_res("multu_after_rst", 32'd0, 32'd42, 1'b0);

        run_op(OP_DIVU, 32'd100, 32'd7, 3, lat);
        expect_res("mthi_overwritten", 32'd2, 32'd14, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
